// File: rtl/pixel_stream_tx_if.sv
// pixel_stream_tx_if: 32-bit pixel stream with valid/ready handshake and sof/eol/eof framing
interface pixel_stream_tx_if;
    logic [31:0] data_out;
    logic        valid;
    logic        ready;
    logic        sof;
    logic        eol;
    logic        eof;
    modport master (output data_out, valid, sof, eol, eof, input ready);
    modport slave  (input data_out, valid, sof, eol, eof, output ready);
endinterface

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: reads one frame from a sync-read frame memory and streams it as framed 32-bit beats
module pixel_stream_tx #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int ADDR_W    = 19,
    parameter bit BOTTOM_UP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    pixel_stream_tx_if.master tx,
    output logic              busy,
    output logic              done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
    typedef struct packed {
        logic [23:0] pix;
        logic        sof;
        logic        eol;
        logic        eof;
    } ent_t;
    state_t            state, nxt;
    logic [XW-1:0]     x_rd;
    logic [YW-1:0]     y_rd;
    logic              x_last, last, pend, pop, issue, head_valid;
    logic [2:0]        pend_flags;
    logic [1:0]        cnt;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] row;
    ent_t              q [2];
    ent_t              q_in;
    assign x_last     = x_rd == XW'(WIDTH - 1);
    assign last       = x_last && y_rd == YW'(HEIGHT - 1);
    assign head_valid = cnt != 2'd0;
    assign pop        = head_valid && tx.ready;
    // Occupancy counts the pop happening this cycle so reads keep pace at one beat per cycle
    assign occ        = 3'(cnt) + 3'(pend) - 3'(pop);
    assign issue      = state == READ && occ < 3'd2;
    assign row        = BOTTOM_UP ? ADDR_W'(HEIGHT - 1) - ADDR_W'(y_rd) : ADDR_W'(y_rd);
    assign mem_rd_en  = issue;
    assign mem_addr   = issue ? row * ADDR_W'(WIDTH) + ADDR_W'(x_rd) : '0;
    assign q_in       = {mem_rdata, pend_flags};
    assign tx.valid    = head_valid;
    assign tx.data_out = head_valid ? {8'h00, q[0].pix} : 32'h0;
    assign tx.sof      = head_valid && q[0].sof;
    assign tx.eol      = head_valid && q[0].eol;
    assign tx.eof      = head_valid && q[0].eof;
    assign busy = state == READ || state == DRAIN;
    assign done = state == FIN;
    // Next-state: drain ends once the last beat leaves the FIFO with nothing in flight
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = start ? READ : IDLE;
            READ:    nxt = issue && last ? DRAIN : READ;
            DRAIN:   nxt = !pend && (cnt == 2'd0 || (cnt == 2'd1 && pop)) ? FIN : DRAIN;
            default: nxt = IDLE;
        endcase
    end
    // State, read counters, in-flight read tracking and 2-entry FIFO (head always in q[0])
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x_rd  <= '0;
            y_rd  <= '0;
            pend  <= 1'b0;
            cnt   <= 2'd0;
        end else begin
            state <= nxt;
            pend  <= issue;
            if (state == IDLE) begin
                x_rd <= '0;
                y_rd <= '0;
            end else if (issue) begin
                x_rd <= x_last ? '0 : x_rd + 1'b1;
                if (x_last)
                    y_rd <= y_rd + 1'b1;
            end
            if (pend && !pop) begin
                if (cnt == 2'd0)
                    q[0] <= q_in;
                else
                    q[1] <= q_in;
                cnt <= cnt + 2'd1;
            end else if (!pend && pop) begin
                q[0] <= q[1];
                cnt  <= cnt - 2'd1;
            end else if (pend && pop) begin
                q[0] <= cnt == 2'd1 ? q_in : q[1];
                q[1] <= q_in;
            end
        end
        if (issue)
            pend_flags <= {x_rd == '0 && y_rd == '0, x_last, last};
    end
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: directed checks of a 4x3 frame, top-down and bottom-up, with backpressure, restart and reset
module tb_pixel_stream_tx;
    logic        clk = 1'b0;
    logic        reset, start, rec;
    logic        rd0, rd1, busy0, busy1, done0, done1;
    logic [3:0]  addr0, addr1;
    logic [23:0] rdata0, rdata1;
    logic [31:0] sof_data1;
    logic [3:0]  addr_q[$];
    logic [15:0] pat = 16'hA769;
    int          n_vec = 0;
    int          n_bad = 0;
    pixel_stream_tx_if s0 ();
    pixel_stream_tx_if s1 ();
    always #5 clk = ~clk;
    pixel_stream_tx #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4), .BOTTOM_UP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .mem_rd_en(rd0), .mem_addr(addr0),
        .mem_rdata(rdata0), .tx(s0.master), .busy(busy0), .done(done0));
    pixel_stream_tx #(.WIDTH(4), .HEIGHT(3), .ADDR_W(4), .BOTTOM_UP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_rdata(rdata1), .tx(s1.master), .busy(busy1), .done(done1));
    // Frame memories: word k holds 24'h000101*k, one-cycle read latency
    always @(posedge clk) begin
        if (rd0) rdata0 <= 24'(addr0) * 24'h000101;
        if (rd1) rdata1 <= 24'(addr1) * 24'h000101;
    end
    // Record the bottom-up instance's read addresses and its sof beat
    always @(negedge clk) begin
        if (rec) begin
            if (rd1) addr_q.push_back(addr1);
            if (s1.valid && s1.sof) sof_data1 = s1.data_out;
        end
    end
    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run(input bit rnd, input int restart_at, input int abort_at);
        int c = 0;
        int k = 0;
        int pi = 0;
        logic stall = 1'b0;
        logic [35:0] cur, held;
        @(negedge clk);
        chk("idle_busy", 36'(busy0), 36'd0);
        start = 1'b1;
        @(negedge clk);
        while (c < 200) begin
            start = 1'b0;
            s0.ready = rnd ? pat[pi % 16] : 1'b1;
            pi++;
            cur = {s0.valid, s0.sof, s0.eol, s0.eof, s0.data_out};
            if (stall) chk("hold", cur, held);
            if (!rnd && k == 0 && c <= 2) chk("latency", 36'(s0.valid), 36'(c == 2));
            if (s0.valid && s0.ready) begin
                chk("data", 36'(s0.data_out), 36'(32'(k) * 32'h101));
                chk("sof", 36'(s0.sof), 36'(k == 0));
                chk("eol", 36'(s0.eol), 36'(k % 4 == 3));
                chk("eof", 36'(s0.eof), 36'(k == 11));
                if (!rnd) chk("beat_cycle", 36'(c), 36'(k + 2));
                k++;
                if (k == restart_at) start = 1'b1;
            end
            stall = s0.valid && !s0.ready;
            held = cur;
            if (done0) begin
                chk("busy_at_done", 36'(busy0), 36'd0);
                if (!rnd) chk("done_cycle", 36'(c), 36'd14);
                break;
            end
            if (abort_at >= 0 && k > abort_at) break;
            @(negedge clk);
            c++;
        end
        chk("timeout", 36'(c < 200), 36'd1);
        if (abort_at >= 0) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("rst_valid", 36'(s0.valid), 36'd0);
            chk("rst_busy", 36'(busy0), 36'd0);
            for (int i = 0; i < 4; i++) begin
                chk("rst_no_done", 36'({done0, s0.valid}), 36'd0);
                @(negedge clk);
            end
        end else begin
            chk("beats", 36'(k), 36'd12);
        end
    endtask
    initial begin
        reset = 1'b1;
        start = 1'b0;
        rec = 1'b0;
        s0.ready = 1'b0;
        s1.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", {s0.valid, s0.sof, s0.eol, s0.eof, s0.data_out}, 36'd0);
        chk("rst_ctl", 36'({rd0, addr0, busy0, done0}), 36'd0);
        chk("rst_bu_addr", 36'({rd1, addr1}), 36'd0);
        reset = 1'b0;
        rec = 1'b1;
        run(1'b0, -1, -1);
        rec = 1'b0;
        chk("bu_reads", 36'(addr_q.size()), 36'd12);
        for (int i = 0; i < 12 && i < addr_q.size(); i++)
            chk("bu_addr", 36'(addr_q[i]), 36'((2 - i / 4) * 4 + i % 4));
        chk("bu_sof_data", 36'(sof_data1), 36'(32'h000808));
        run(1'b1, -1, -1);
        run(1'b0, 5, -1);
        run(1'b0, -1, -1);
        run(1'b0, -1, 6);
        run(1'b0, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
